// File: rtl/gpr_serial_port_if.sv
// Request/response bundle between the host-side controller and the GPR serial port.
interface gpr_serial_port_if #(
    parameter int WIDTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic             req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/gpr_serial_port.sv
// Parallel-to-bit-serial access port for the 2-entry serial GPR file.
// Writes stream the latched word LSB first into the addressed register;
// reads recirculate the register's own LSB so it is preserved, while the
// same bits are assembled into the response word.
module gpr_serial_port #(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    gpr_serial_port_if.slave   bus,
    output logic               o_busy,
    output logic               o_con_shift,
    output logic               o_con_write,
    output logic               o_data,
    output logic               o_rd_addr,
    input  logic               i_data
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic             addr_q;
    logic             wr_q;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic [WIDTH-1:0] rdata_q;
    logic             accept;
    logic             last_bit;

    assign accept   = (state_q == IDLE) && bus.req_valid;
    assign last_bit = (cnt_q == CNT_LAST);
    // Writes drain the word; reads collect the incoming GPR bit at the top
    assign sreg_d   = {(wr_q ? 1'b0 : i_data), sreg_q[WIDTH-1:1]};

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = SHIFT;
            SHIFT:   if (last_bit)      state_d = wr_q ? IDLE : RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: strobes are combinational so the GPR samples them on the same edge
    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.rsp_valid = (state_q == RESP);
        bus.rsp_rdata = rdata_q;
        o_busy        = (state_q != IDLE);
        o_con_shift   = (state_q == SHIFT);
        o_con_write   = (state_q == SHIFT);
        o_rd_addr     = addr_q;
        o_data        = 1'b0;
        if (state_q == SHIFT) o_data = wr_q ? sreg_q[0] : i_data;
    end

    // Request latch, bit counter, shift register and response word
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q   <= '0;
            addr_q  <= 1'b0;
            wr_q    <= 1'b0;
            sreg_q  <= '0;
            rdata_q <= '0;
        end else if (accept) begin
            cnt_q  <= '0;
            addr_q <= bus.req_addr;
            wr_q   <= bus.req_write;
            sreg_q <= bus.req_wdata;
        end else if (state_q == SHIFT) begin
            cnt_q  <= cnt_q + 1'b1;
            sreg_q <= sreg_d;
            // Response word only updates when a read completes, so it holds otherwise
            if (last_bit && !wr_q) rdata_q <= sreg_d;
        end
    end
endmodule

// File: tb/tb_gpr_serial_port.sv
module tb_gpr_serial_port;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    logic busy, con_shift, con_write, sdata, rd_addr, gpr_out;
    logic [W-1:0] ry, rx;
    int checks = 0;
    int errors = 0;

    gpr_serial_port_if #(.WIDTH(W)) bus ();

    gpr_serial_port #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus),
        .o_busy      (busy),
        .o_con_shift (con_shift),
        .o_con_write (con_write),
        .o_data      (sdata),
        .o_rd_addr   (rd_addr),
        .i_data      (gpr_out)
    );

    always #5 clk = ~clk;

    // Behavioural 2-entry serial GPR: shifts right, new bit enters at the MSB
    always @(posedge clk) begin
        if (rst) begin
            ry <= '0;
            rx <= '0;
        end else if (con_shift && con_write) begin
            if (rd_addr) rx <= {sdata, rx[W-1:1]};
            else         ry <= {sdata, ry[W-1:1]};
        end
    end
    assign gpr_out = rd_addr ? rx[0] : ry[0];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete request; rsp_ready is assumed 1. With hold=1 req_valid stays high.
    task automatic issue(input logic w, input logic a, input logic [W-1:0] d,
                         input logic [W-1:0] exp_rd, input bit hold, input string tag);
        int n;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            step();
            n++;
        end
        chk({tag, "_ready_wait"}, {31'd0, n < 50}, 32'd1);
        step();
        if (!hold) bus.req_valid = 1'b0;
        for (int k = 0; k < W; k++) begin
            chk({tag, "_shift"}, {31'd0, con_shift}, 32'd1);
            chk({tag, "_rdaddr"}, {31'd0, rd_addr}, {31'd0, a});
            if (w) chk({tag, "_sdata"}, {31'd0, sdata}, {31'd0, d[k]});
            step();
        end
        chk({tag, "_shift_end"}, {31'd0, con_shift}, 32'd0);
        if (w) begin
            chk({tag, "_ready_after_wr"}, {31'd0, bus.req_ready}, 32'd1);
        end else begin
            chk({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
            chk({tag, "_rdata"}, {24'd0, bus.rsp_rdata}, {24'd0, exp_rd});
            step();
            chk({tag, "_rsp_done"}, {31'd0, bus.rsp_valid}, 32'd0);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 1'b0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;

        // Test 1: reset
        step();
        step();
        rst = 1'b0;
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
        chk("rst_con_shift", {31'd0, con_shift}, 32'd0);
        chk("rst_con_write", {31'd0, con_write}, 32'd0);
        chk("rst_data", {31'd0, sdata}, 32'd0);
        chk("rst_rd_addr", {31'd0, rd_addr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_ry", {24'd0, ry}, 32'd0);
        chk("rst_rx", {24'd0, rx}, 32'd0);

        // Test 2: write 0xA5 to rx
        issue(1'b1, 1'b1, 8'hA5, 8'h00, 1'b0, "wr_a5");
        chk("wr_a5_rx", {24'd0, rx}, 32'h0A5);
        chk("wr_a5_ry", {24'd0, ry}, 32'h000);
        chk("wr_a5_busy", {31'd0, busy}, 32'd0);

        // Test 3: read rx back; register preserved
        issue(1'b0, 1'b1, 8'h00, 8'hA5, 1'b0, "rd_a5");
        chk("rd_a5_rx_kept", {24'd0, rx}, 32'h0A5);

        // Test 4: response back-pressure with a pending request
        bus.rsp_ready = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 1'b1;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        for (int k = 0; k < W; k++) step();
        bus.req_addr  = 1'b0;
        bus.req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("bp_rdata", {24'd0, bus.rsp_rdata}, 32'h0A5);
            chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
            chk("bp_no_shift", {31'd0, con_shift}, 32'd0);
            step();
        end
        bus.rsp_ready = 1'b1;
        chk("bp_rsp_valid_hs", {31'd0, bus.rsp_valid}, 32'd1);
        step();
        chk("bp_after_hs_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("bp_after_hs_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("bp_rdata_hold", {24'd0, bus.rsp_rdata}, 32'h0A5);
        step();
        bus.req_valid = 1'b0;
        chk("bp_pending_accepted", {31'd0, con_shift}, 32'd1);
        chk("bp_pending_addr", {31'd0, rd_addr}, 32'd0);
        for (int k = 0; k < W; k++) step();
        chk("bp_pending_rsp", {31'd0, bus.rsp_valid}, 32'd1);
        chk("bp_pending_rdata", {24'd0, bus.rsp_rdata}, 32'h000);
        step();
        chk("bp_rx_kept", {24'd0, rx}, 32'h0A5);

        // Test 5: reset in the middle of a write
        bus.req_write = 1'b1;
        bus.req_addr  = 1'b0;
        bus.req_wdata = 8'hFF;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        step();
        step();
        step();
        chk("mid_shift_active", {31'd0, con_shift}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("mid_ry", {24'd0, ry}, 32'd0);
        chk("mid_rdaddr", {31'd0, rd_addr}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            chk("mid_no_shift", {31'd0, con_shift}, 32'd0);
            chk("mid_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
            chk("mid_no_data", {31'd0, sdata}, 32'd0);
            step();
        end
        chk("mid_ry_final", {24'd0, ry}, 32'd0);

        // Test 6: back-to-back requests with req_valid held high
        issue(1'b1, 1'b0, 8'h3C, 8'h00, 1'b1, "b2b_wr0");
        issue(1'b1, 1'b1, 8'h81, 8'h00, 1'b1, "b2b_wr1");
        issue(1'b0, 1'b0, 8'h00, 8'h3C, 1'b1, "b2b_rd0");
        issue(1'b0, 1'b1, 8'h00, 8'h81, 1'b0, "b2b_rd1");
        chk("b2b_ry", {24'd0, ry}, 32'h03C);
        chk("b2b_rx", {24'd0, rx}, 32'h081);
        chk("b2b_rdata_hold", {24'd0, bus.rsp_rdata}, 32'h081);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
